// File: rtl/counter_pkg.sv
// Shared encodings for the counter family.
// Holds FSM state codes and the default counter width.
package counter_pkg;

  localparam int CNT_WIDTH = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/down_cnt_core.sv
// Down-counter datapath: reload register, counter register
// and zero detect. Decrement saturates at zero.
module down_cnt_core
  import counter_pkg::*;
#(
  parameter int W = CNT_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         reload_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] rld_q, rld_d;
  logic [W-1:0] cnt_q, cnt_d;

  assign zero_o = (cnt_q == '0);
  assign cnt_o  = cnt_q;

  // load beats reload beats decrement
  always_comb begin
    rld_d = rld_q;
    cnt_d = cnt_q;
    if (load_i) begin
      rld_d = load_val_i;
      cnt_d = load_val_i;
    end else if (reload_i) begin
      cnt_d = rld_q;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rld_q <= '1;
      cnt_q <= '0;
    end else begin
      rld_q <= rld_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with terminal-count pulse,
// one-shot and auto-reload modes.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int CNT_WIDTH = counter_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 auto_reload,
  output logic [CNT_WIDTH-1:0] counter,
  output logic                 tc,
  output logic                 busy
);

  state_e state_q;
  logic   tc_q;
  logic   busy_q;
  logic   zero;
  logic   reload;
  logic   dec;

  always_comb begin
    reload = 1'b0;
    dec    = 1'b0;
    if (!stop && !load) begin
      if (state_q == ST_IDLE) begin
        reload = start;
      end else if (zero) begin
        reload = auto_reload;
      end else begin
        dec = 1'b1;
      end
    end
  end

  down_cnt_core #(
    .W(CNT_WIDTH)
  ) u_core (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (load),
    .load_val_i(load_value),
    .reload_i  (reload),
    .dec_i     (dec),
    .cnt_o     (counter),
    .zero_o    (zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else if (stop) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else if (load) begin
      tc_q <= 1'b0;
      if (state_q == ST_IDLE && start) begin
        state_q <= ST_RUN;
        busy_q  <= 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tc_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          tc_q <= zero;
          if (zero && !auto_reload) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tc_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tc   = tc_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed vector bench for down_counter_timer.
// Table of per-cycle stimulus with expected outputs.
module tb_down_counter_timer;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [2:0] lv;
    logic       st;
    logic       sp;
    logic       ar;
    logic [2:0] ec;
    logic       et;
    logic       eb;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_value = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;
  logic [2:0] counter;
  logic       tc;
  logic       busy;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  down_counter_timer #(
    .CNT_WIDTH(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .counter    (counter),
    .tc         (tc),
    .busy       (busy)
  );

  function automatic void v(logic r, logic l, logic [2:0] lv,
                            logic s, logic p, logic a,
                            logic [2:0] c, logic t, logic b);
    vec_t e;
    e.rst = r; e.ld = l; e.lv = lv; e.st = s;
    e.sp = p; e.ar = a; e.ec = c; e.et = t; e.eb = b;
    tbl.push_back(e);
  endfunction

  task automatic step(input vec_t e, input string nm);
    @(negedge clk);
    reset = e.rst; load = e.ld; load_value = e.lv;
    start = e.st; stop = e.sp; auto_reload = e.ar;
    @(posedge clk);
    #1;
    checks++;
    if (counter !== e.ec || tc !== e.et || busy !== e.eb) begin
      errors++;
      $display("FAIL %s: got cnt=%0d tc=%b busy=%b, want cnt=%0d tc=%b busy=%b",
               nm, counter, tc, busy, e.ec, e.et, e.eb);
    end
  endtask

  initial begin
    // reset, then start from all-ones reload
    v(1,0,0,0,0,0, 0,0,0);
    v(0,0,0,1,0,0, 7,0,1);
    for (int k = 6; k >= 0; k--) v(0,0,0,0,0,0, 3'(k),0,1);
    v(0,0,0,0,0,0, 0,1,0);
    v(0,0,0,0,0,0, 0,0,0);
    // load 5 with start, one-shot
    v(0,1,5,1,0,0, 5,0,1);
    for (int k = 4; k >= 0; k--) v(0,0,0,0,0,0, 3'(k),0,1);
    v(0,0,0,0,0,0, 0,1,0);
    v(0,0,0,0,0,0, 0,0,0);
    // load 2, auto reload
    v(0,1,2,1,0,1, 2,0,1);
    v(0,0,0,0,0,1, 1,0,1);
    v(0,0,0,0,0,1, 0,0,1);
    v(0,0,0,0,0,1, 2,1,1);
    v(0,0,0,0,0,1, 1,0,1);
    v(0,0,0,0,0,1, 0,0,1);
    v(0,0,0,0,0,1, 2,1,1);
    v(0,0,0,0,1,1, 2,0,0);
    // load 0, auto reload: tc stuck high
    v(0,1,0,1,0,1, 0,0,1);
    v(0,0,0,0,0,1, 0,1,1);
    v(0,0,0,0,0,1, 0,1,1);
    v(0,0,0,0,0,1, 0,1,1);
    v(0,0,0,0,1,1, 0,0,0);
    // load 6, stop at 3, restart reloads 6
    v(0,1,6,1,0,0, 6,0,1);
    v(0,0,0,0,0,0, 5,0,1);
    v(0,0,0,0,0,0, 4,0,1);
    v(0,0,0,0,0,0, 3,0,1);
    v(0,0,0,0,1,0, 3,0,0);
    v(0,0,0,0,0,0, 3,0,0);
    v(0,0,0,1,0,0, 6,0,1);
    v(0,0,0,0,0,0, 5,0,1);
    v(0,0,0,0,0,0, 4,0,1);
    // load 1 mid-run
    v(0,1,1,0,0,0, 1,0,1);
    v(0,0,0,0,0,0, 0,0,1);
    v(0,0,0,0,0,0, 0,1,0);
    v(0,0,0,0,0,0, 0,0,0);
    // start uses reload 1; stop+load together; start in RUN ignored
    v(0,0,0,1,0,0, 1,0,1);
    v(0,1,4,0,1,0, 4,0,0);
    v(0,0,0,1,0,0, 4,0,1);
    v(0,0,0,1,0,0, 3,0,1);

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // reset mid-run discards reload value
    begin
      vec_t e;
      e = '{rst:0, ld:1, lv:3'd3, st:1, sp:0, ar:0, ec:3'd3, et:0, eb:1};
      step(e, "mr_load3");
      e = '{rst:0, ld:0, lv:3'd0, st:0, sp:0, ar:0, ec:3'd2, et:0, eb:1};
      step(e, "mr_dec");
      e = '{rst:1, ld:0, lv:3'd0, st:0, sp:0, ar:0, ec:3'd0, et:0, eb:0};
      step(e, "mr_reset");
      e = '{rst:0, ld:0, lv:3'd0, st:1, sp:0, ar:0, ec:3'd7, et:0, eb:1};
      step(e, "mr_start7");
      e = '{rst:0, ld:0, lv:3'd0, st:0, sp:0, ar:0, ec:3'd6, et:0, eb:1};
      step(e, "mr_dec6");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
